// File: rtl/core_halt_scorer.sv
// rtl/core_halt_scorer.sv - halts the core after a NOP run, then scores dmem against an answer key
//
// Purpose:
//   Watches the fetched instruction stream for NOP_LIMIT consecutive NOPs
//   (program end). It then halts the core and compares data memory with the
//   answer-key memory, one word per cycle over NUM_WORDS words from byte
//   address 0. The result is reported as a match score and the first
//   mismatch address.
//
// Optional feature:
//   SCORER_MISS_MAP_EN - adds the miss_map output. Bit i is set when word i
//   mismatched.
//
// Ports:
//   clk              in   clock, rising edge
//   rst              in   asynchronous reset, active-high
//   imem_data        in   instruction fetched this cycle
//   core_halt        out  freezes core PC/regfile/dmem writes
//   rd_addr          out  byte address driven to dmem and key memories
//   dut_rd_data      in   dmem word at rd_addr (combinational read)
//   key_rd_data      in   answer-key word at rd_addr (combinational read)
//   busy             out  scan in progress
//   done             out  scoring complete, sticky until reset
//   score            out  number of matching words
//   first_miss_valid out  at least one mismatch seen
//   first_miss_addr  out  byte address of the first mismatch
//   miss_map         out  per-word mismatch flags (SCORER_MISS_MAP_EN only)

module core_halt_scorer #(
    parameter int                    WORD_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    NUM_WORDS  = 32,
    parameter int                    NOP_LIMIT  = 10,
    parameter logic [WORD_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [WORD_WIDTH-1:0]            imem_data,
    output logic                             core_halt,
    output logic [ADDR_WIDTH-1:0]            rd_addr,
    input  logic [WORD_WIDTH-1:0]            dut_rd_data,
    input  logic [WORD_WIDTH-1:0]            key_rd_data,
    output logic                             busy,
    output logic                             done,
    output logic [$clog2(NUM_WORDS+1)-1:0]   score,
    output logic                             first_miss_valid,
    output logic [ADDR_WIDTH-1:0]            first_miss_addr
`ifdef SCORER_MISS_MAP_EN
    ,
    output logic [NUM_WORDS-1:0]             miss_map
`endif
);

    localparam int SCORE_W = $clog2(NUM_WORDS + 1);
    localparam int NOP_W   = $clog2(NOP_LIMIT + 1);
    localparam int IDX_W   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                r_state,     w_state;
    logic [NOP_W-1:0]      r_nop_cnt,   w_nop_cnt;
    logic                  r_core_halt, w_core_halt;
    logic [ADDR_WIDTH-1:0] r_rd_addr,   w_rd_addr;
    logic                  r_busy,      w_busy;
    logic                  r_done,      w_done;
    logic [SCORE_W-1:0]    r_score,     w_score;
    logic                  r_fmv,       w_fmv;
    logic [ADDR_WIDTH-1:0] r_fma,       w_fma;
    // Word index kept separately from rd_addr so the end-of-scan test does
    // not depend on the address arithmetic.
    logic [IDX_W-1:0]      r_idx,       w_idx;
`ifdef SCORER_MISS_MAP_EN
    logic [NUM_WORDS-1:0]  r_miss_map,  w_miss_map;
`endif

    logic w_is_nop;
    logic w_match;

    assign w_is_nop = (imem_data == NOP_INSTR);
    assign w_match  = (dut_rd_data == key_rd_data);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_nop_cnt   <= '0;
            r_core_halt <= 1'b0;
            r_rd_addr   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_score     <= '0;
            r_fmv       <= 1'b0;
            r_fma       <= '0;
            r_idx       <= '0;
`ifdef SCORER_MISS_MAP_EN
            r_miss_map  <= '0;
`endif
        end else begin
            r_state     <= w_state;
            r_nop_cnt   <= w_nop_cnt;
            r_core_halt <= w_core_halt;
            r_rd_addr   <= w_rd_addr;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_score     <= w_score;
            r_fmv       <= w_fmv;
            r_fma       <= w_fma;
            r_idx       <= w_idx;
`ifdef SCORER_MISS_MAP_EN
            r_miss_map  <= w_miss_map;
`endif
        end
    end

    always_comb begin
        w_state     = r_state;
        w_nop_cnt   = r_nop_cnt;
        w_core_halt = r_core_halt;
        w_rd_addr   = r_rd_addr;
        w_busy      = r_busy;
        w_done      = r_done;
        w_score     = r_score;
        w_fmv       = r_fmv;
        w_fma       = r_fma;
        w_idx       = r_idx;
`ifdef SCORER_MISS_MAP_EN
        w_miss_map  = r_miss_map;
`endif

        case (r_state)
            ST_RUN: begin
                if (w_is_nop) begin
                    // The NOP that completes the run is counted on this edge,
                    // so the halt happens on the edge that sees NOP number
                    // NOP_LIMIT.
                    if (r_nop_cnt == NOP_W'(NOP_LIMIT - 1)) begin
                        w_state     = ST_SCAN;
                        w_core_halt = 1'b1;
                        w_busy      = 1'b1;
                        w_rd_addr   = '0;
                        w_idx       = '0;
                        w_nop_cnt   = '0;
                    end else begin
                        w_nop_cnt = r_nop_cnt + NOP_W'(1);
                    end
                end else begin
                    w_nop_cnt = '0;
                end
            end

            ST_SCAN: begin
                if (w_match) begin
                    w_score = r_score + SCORE_W'(1);
                end else begin
`ifdef SCORER_MISS_MAP_EN
                    w_miss_map[r_idx] = 1'b1;
`endif
                    if (!r_fmv) begin
                        w_fmv = 1'b1;
                        w_fma = r_rd_addr;
                    end
                end
                // rd_addr holds on the last word so it never runs past the
                // compared region.
                if (r_idx == IDX_W'(NUM_WORDS - 1)) begin
                    w_state = ST_DONE;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                end else begin
                    w_rd_addr = r_rd_addr + ADDR_WIDTH'(4);
                    w_idx     = r_idx + IDX_W'(1);
                end
            end

            ST_DONE: begin
                // Terminal until reset; every output holds.
            end

            default: begin
                w_state = ST_RUN;
            end
        endcase
    end

    assign core_halt        = r_core_halt;
    assign rd_addr          = r_rd_addr;
    assign busy             = r_busy;
    assign done             = r_done;
    assign score            = r_score;
    assign first_miss_valid = r_fmv;
    assign first_miss_addr  = r_fma;
`ifdef SCORER_MISS_MAP_EN
    assign miss_map         = r_miss_map;
`endif

endmodule

// File: tb/tb_core_halt_scorer.sv
// tb/tb_core_halt_scorer.sv - self-checking bench for core_halt_scorer

module tb_core_halt_scorer;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] ADDI = 32'h0010_0093;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_data = 32'h0;
    logic        core_halt;
    logic [31:0] rd_addr;
    logic [31:0] dut_rd_data;
    logic [31:0] key_rd_data;
    logic        busy;
    logic        done;
    logic [5:0]  score;
    logic        first_miss_valid;
    logic [31:0] first_miss_addr;
`ifdef SCORER_MISS_MAP_EN
    logic [31:0] miss_map;
`endif

    logic [31:0] dmem [32];
    logic [31:0] kmem [32];
    logic        ovr = 1'b0;
    logic [31:0] ovr_val = 32'h0;

    assign dut_rd_data = ovr ? ovr_val : dmem[rd_addr[6:2]];
    assign key_rd_data = kmem[rd_addr[6:2]];

    always #5 clk = ~clk;

    core_halt_scorer dut (
        .clk              (clk),
        .rst              (rst),
        .imem_data        (imem_data),
        .core_halt        (core_halt),
        .rd_addr          (rd_addr),
        .dut_rd_data      (dut_rd_data),
        .key_rd_data      (key_rd_data),
        .busy             (busy),
        .done             (done),
        .score            (score),
        .first_miss_valid (first_miss_valid),
        .first_miss_addr  (first_miss_addr)
`ifdef SCORER_MISS_MAP_EN
        ,
        .miss_map         (miss_map)
`endif
    );

    typedef struct {
        logic [31:0] mask;
        logic [5:0]  score;
        logic        fmv;
        logic [31:0] fma;
    } vec_t;

    typedef struct {
        logic [5:0]  score;
        logic        fmv;
        logic [31:0] fma;
        logic [31:0] map;
    } exp_t;

    vec_t vecs[5];
    exp_t sb_q[$];
    exp_t last_exp;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic load_mem(input logic [31:0] mask);
        for (int i = 0; i < 32; i++) begin
            dmem[i] = $urandom;
            kmem[i] = mask[i] ? (dmem[i] ^ 32'h5A00_0001) : dmem[i];
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        imem_data = 32'h0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send(input logic [31:0] instr, input int n);
        for (int i = 0; i < n; i++) begin
            imem_data = instr;
            @(negedge clk);
        end
        imem_data = 32'h0;
    endtask

    task automatic push_exp(input logic [5:0] s, input logic v, input logic [31:0] a, input logic [31:0] m);
        exp_t e;
        e.score = s; e.fmv = v; e.fma = a; e.map = m;
        sb_q.push_back(e);
    endtask

    task automatic finish_scan(input string tag);
        int   cyc;
        exp_t e;
        cyc = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_scan_len"}, cyc, 32);
        if (sb_q.size() == 0) begin
            total++; bad++;
            $display("FAIL %s_sb_empty actual=0 expected=1", tag);
        end else begin
            e = sb_q.pop_front();
            last_exp = e;
            check({tag, "_score"}, {26'h0, score}, {26'h0, e.score});
            check({tag, "_fmv"}, {31'h0, first_miss_valid}, {31'h0, e.fmv});
            check({tag, "_fma"}, first_miss_addr, e.fma);
`ifdef SCORER_MISS_MAP_EN
            check({tag, "_map"}, miss_map, e.map);
`endif
            check({tag, "_done_busy_halt"}, {29'h0, done, busy, core_halt}, 32'h5);
            check({tag, "_rd_addr"}, rd_addr, 32'h7C);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ctl"}, {28'h0, core_halt, busy, done, first_miss_valid}, 32'h0);
        check({tag, "_rd_addr"}, rd_addr, 32'h0);
        check({tag, "_score"}, {26'h0, score}, 32'h0);
        check({tag, "_fma"}, first_miss_addr, 32'h0);
`ifdef SCORER_MISS_MAP_EN
        check({tag, "_map"}, miss_map, 32'h0);
`endif
    endtask

    initial begin
        vecs[0] = '{mask: 32'h0000_0000, score: 6'd32, fmv: 1'b0, fma: 32'h00};
        vecs[1] = '{mask: 32'h0010_0020, score: 6'd30, fmv: 1'b1, fma: 32'h14};
        vecs[2] = '{mask: 32'hFFFF_FFFF, score: 6'd0,  fmv: 1'b1, fma: 32'h00};
        vecs[3] = '{mask: 32'h8000_0000, score: 6'd31, fmv: 1'b1, fma: 32'h7C};
        vecs[4] = '{mask: 32'h0000_0001, score: 6'd31, fmv: 1'b1, fma: 32'h00};

        for (int i = 0; i < 32; i++) begin
            dmem[i] = 32'h0;
            kmem[i] = 32'h0;
        end

        // Reset state while rst is held.
        #2;
        check_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;

        // Table-driven scans.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            load_mem(vecs[v].mask);
            push_exp(vecs[v].score, vecs[v].fmv, vecs[v].fma, vecs[v].mask);
            send(NOP, 10);
            check($sformatf("vec%0d_halt", v), {30'h0, core_halt, busy}, 32'h3);
            finish_scan($sformatf("vec%0d", v));
        end

        // Post-done stability under toggling inputs (follows vec4).
        for (int c = 0; c < 50; c++) begin
            imem_data = (c % 2 == 0) ? NOP : $urandom;
            ovr = 1'b1;
            ovr_val = $urandom;
            @(negedge clk);
        end
        ovr = 1'b0;
        imem_data = 32'h0;
        check("hold_score", {26'h0, score}, {26'h0, last_exp.score});
        check("hold_ctl", {28'h0, done, core_halt, busy, first_miss_valid}, 32'hD);
        check("hold_fma", first_miss_addr, last_exp.fma);

        // Interrupted NOP run: 9 NOPs, an addi, then a fresh run of 10.
        do_reset();
        load_mem(32'h0);
        push_exp(6'd32, 1'b0, 32'h0, 32'h0);
        send(NOP, 9);
        check("run1_no_halt", {31'h0, core_halt}, 32'h0);
        send(ADDI, 1);
        send(NOP, 9);
        check("run2_9_no_halt", {31'h0, core_halt}, 32'h0);
        send(NOP, 1);
        check("run2_10_halt", {31'h0, core_halt}, 32'h1);
        finish_scan("run2");

        // NOP run straddling reset starts counting again from zero.
        do_reset();
        send(NOP, 5);
        do_reset();
        send(NOP, 9);
        check("straddle_no_halt", {31'h0, core_halt}, 32'h0);
        send(NOP, 1);
        check("straddle_halt", {31'h0, core_halt}, 32'h1);

        // Reset during scan cycle 12, then full re-run.
        for (int c = 0; c < 12; c++) @(negedge clk);
        check("midscan_busy", {31'h0, busy}, 32'h1);
        rst = 1'b1;
        #1;
        check_reset_vals("midscan_rst");
        @(negedge clk);
        rst = 1'b0;
        load_mem(32'h0010_0020);
        push_exp(6'd30, 1'b1, 32'h14, 32'h0010_0020);
        send(NOP, 10);
        finish_scan("rerun");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
